// File: rtl/parity_pkg.sv
// rtl/parity_pkg.sv - shared FSM state type and default sizing for the parity frame transmitter
//
// Contents:
//   DEF_WIDTH         default data word width in bits
//   DEF_CLKS_PER_BIT  default clock cycles per serial bit
//   state_t           transmitter FSM states

package parity_pkg;

    localparam int DEF_WIDTH        = 8;
    localparam int DEF_CLKS_PER_BIT = 4;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

endpackage

// File: rtl/parity_frame_tx_if.sv
// rtl/parity_frame_tx_if.sv - word handshake between a data source and the parity frame transmitter
//
// Signals:
//   data_in     word to transmit (WIDTH bits), source to transmitter
//   data_valid  data_in holds a word, source to transmitter
//   data_ready  transmitter can accept a word this cycle, transmitter to source
//   inject_err  invert the parity bit of the accepted frame (only with PARITY_INJECT_EN)
// Modports: master (word source), slave (transmitter).
// Build option: PARITY_INJECT_EN adds inject_err.

interface parity_frame_tx_if #(
    parameter int WIDTH = parity_pkg::DEF_WIDTH
);

    logic [WIDTH-1:0] data_in;
    logic             data_valid;
    logic             data_ready;
`ifdef PARITY_INJECT_EN
    logic             inject_err;

    modport master (output data_in, output data_valid, output inject_err, input data_ready);
    modport slave  (input data_in, input data_valid, input inject_err, output data_ready);
`else
    modport master (output data_in, output data_valid, input data_ready);
    modport slave  (input data_in, input data_valid, output data_ready);
`endif

endinterface

// File: rtl/parity_generator.sv
// rtl/parity_generator.sv - combinational even/odd parity of a word
//
// Ports:
//   data  input  WIDTH  word to examine
//   even  output 1      bit that makes the total count of ones even (XOR of data)
//   odd   output 1      bit that makes the total count of ones odd

module parity_generator #(
    parameter int WIDTH = parity_pkg::DEF_WIDTH
) (
    input  logic [WIDTH-1:0] data,
    output logic             even,
    output logic             odd
);

    assign even = ^data;
    assign odd  = ~(^data);

endmodule

// File: rtl/parity_frame_tx.sv
// rtl/parity_frame_tx.sv - serial transmitter: start bit, data LSB first, parity bit, stop bit
//
// Parameters: WIDTH (data bits), CLKS_PER_BIT (cycles per serial bit), ODD (0 even, 1 odd parity)
// Ports:
//   clk         input   rising-edge clock
//   rst_n       input   asynchronous active-low reset
//   host        slave   word handshake (data_in, data_valid, data_ready[, inject_err])
//   tx_serial   output  serial line, idle high
//   busy        output  a frame is in progress
//   frame_done  output  one-cycle pulse in the first idle cycle after a frame
// Build option: PARITY_INJECT_EN adds host.inject_err, which inverts the parity bit of the frame it is accepted with.

module parity_frame_tx
    import parity_pkg::*;
#(
    parameter int WIDTH        = DEF_WIDTH,
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int ODD          = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    parity_frame_tx_if.slave host,
    output logic             tx_serial,
    output logic             busy,
    output logic             frame_done
);

    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam int BW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic             parity_q, parity_d;
    logic             done_q, done_d;
    logic             ready;
    logic             par_even, par_odd;
    logic             parity_sel;
    logic             period_end;

    // Parity is taken from data_in at the acceptance edge, i.e. from exactly
    // the word that lands in the shift register.
    parity_generator #(.WIDTH(WIDTH)) u_parity (
        .data (host.data_in),
        .even (par_even),
        .odd  (par_odd)
    );

`ifdef PARITY_INJECT_EN
    assign parity_sel = ((ODD != 0) ? par_odd : par_even) ^ host.inject_err;
`else
    assign parity_sel = (ODD != 0) ? par_odd : par_even;
`endif

    assign period_end      = (cnt_q == CNT_LAST);
    assign host.data_ready = ready;
    assign frame_done      = done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            bit_q    <= '0;
            shreg_q  <= '0;
            parity_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            shreg_q  <= shreg_d;
            parity_q <= parity_d;
            done_q   <= done_d;
        end
    end

    // Outputs decode from registered state so reset forces them at once.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        shreg_d   = shreg_q;
        parity_d  = parity_q;
        done_d    = 1'b0;
        ready     = 1'b0;
        busy      = 1'b1;
        tx_serial = 1'b1;

        case (state_q)
            IDLE: begin
                ready = 1'b1;
                busy  = 1'b0;
                if (host.data_valid) begin
                    state_d  = START;
                    cnt_d    = '0;
                    bit_d    = '0;
                    shreg_d  = host.data_in;
                    parity_d = parity_sel;
                end
            end
            START: begin
                tx_serial = 1'b0;
                if (period_end) begin
                    cnt_d   = '0;
                    state_d = DATA;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DATA: begin
                tx_serial = shreg_q[0];
                if (period_end) begin
                    cnt_d   = '0;
                    shreg_d = shreg_q >> 1;
                    if (bit_q == BIT_LAST) begin
                        bit_d   = '0;
                        state_d = PARITY;
                    end else begin
                        bit_d = bit_q + BW'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            PARITY: begin
                tx_serial = parity_q;
                if (period_end) begin
                    cnt_d   = '0;
                    state_d = STOP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            STOP: begin
                tx_serial = 1'b1;
                if (period_end) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                busy    = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

endmodule
